// File: rtl/acq_ctrl_pkg.sv
// Shared types and constants for the acquisition control sequencer.
package acq_ctrl_pkg;

    // Sequencer states; the encoding is visible on state_dbg.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } acq_state_t;

    localparam logic [1:0] CMD_NOP       = 2'b00;
    localparam logic [1:0] CMD_ARM       = 2'b01;
    localparam logic [1:0] CMD_SOFT_TRIG = 2'b10;
    localparam logic [1:0] CMD_ABORT     = 2'b11;

    localparam int PRESCALE_LOG2_DEFAULT = 2;

    // Sampling window covers the wait for a trigger and the post-trigger delay.
    function automatic logic is_sampling(acq_state_t s);
        return (s == ARMED) || (s == DELAY);
    endfunction

    function automatic logic is_busy(acq_state_t s);
        return (s == ARMED) || (s == DELAY) || (s == STOP);
    endfunction

endpackage

// File: rtl/acq_ctrl_sync_edge.sv
// sync_edge: WIDTH-bit two-flop synchroniser. With EDGE_EN=1 the output is a
// registered one-cycle rising-edge strobe of the synchronised signal instead
// of the synchronised level.
module sync_edge #(
    parameter int WIDTH   = 1,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-flop metastability chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    generate
        if (EDGE_EN) begin : g_edge
            logic [WIDTH-1:0] prev_q;
            logic [WIDTH-1:0] rise_q;

            // Registered rising-edge detect on the synchronised level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_q <= '0;
                    rise_q <= '0;
                end else begin
                    prev_q <= sync_q;
                    rise_q <= sync_q & ~prev_q;
                end
            end

            assign q = rise_q;
        end else begin : g_level
            assign q = sync_q;
        end
    endgenerate

endmodule

// File: rtl/acq_ctrl.sv
// acq_ctrl: arm -> trigger -> delay -> stop acquisition sequencer.
// Optional trigger counter enabled by defining ACQ_CTRL_TRIG_COUNT_EN;
// without it trig_count is tied to zero.
//
// state | meaning
// IDLE  | waiting for ARM
// ARMED | sampling, waiting for an accepted trigger
// DELAY | sampling, counting trigger_delay ticks
// STOP  | one-cycle stop-sampling strobe
// DONE  | acquisition complete, waiting for rearm or abort
module acq_ctrl
    import acq_ctrl_pkg::*;
#(
    parameter int PRESCALE_LOG2 = PRESCALE_LOG2_DEFAULT,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       instruction,
    input  logic [1:0]       mode,
    input  logic [5:0]       trigger_delay,
    input  logic             slow_mode,
    input  logic             trig_in,
    output logic             sample_en,
    output logic             stop_pulse,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] trig_count
);

    localparam int PW = (PRESCALE_LOG2 < 1) ? 1 : PRESCALE_LOG2;

    logic [1:0]    instr_s2;
    logic [1:0]    instr_s3_q, instr_s3_d;
    logic          ext_rise;
    logic [8:0]    cfg_meta_q, cfg_sync_q;
    logic [1:0]    mode_s;
    logic [5:0]    delay_s;
    logic          slow_s;

    logic [1:0]    warm_q, warm_d;
    logic          cmd_armed_q, cmd_armed_d;
    logic          cmd_fire;
    logic          cmd_arm, cmd_soft, cmd_abort;
    logic          trig_acc;
    logic          tick;
    logic          trig_taken;

    acq_state_t    state_q, state_d;
    logic [5:0]    dly_cnt_q, dly_cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sample_en_q, stop_pulse_q, busy_q, done_q;

    sync_edge #(.WIDTH(2), .EDGE_EN(1'b0)) u_sync_instr (
        .clk (clk),
        .rst (rst),
        .d   (instruction),
        .q   (instr_s2)
    );

    sync_edge #(.WIDTH(1), .EDGE_EN(1'b1)) u_sync_trig (
        .clk (clk),
        .rst (rst),
        .d   (trig_in),
        .q   (ext_rise)
    );

    // Quasi-static configuration only moves while IDLE; a plain two-flop chain suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_meta_q <= '0;
            cfg_sync_q <= '0;
        end else begin
            cfg_meta_q <= {slow_mode, trigger_delay, mode};
            cfg_sync_q <= cfg_meta_q;
        end
    end

    assign mode_s  = cfg_sync_q[1:0];
    assign delay_s = cfg_sync_q[7:2];
    assign slow_s  = cfg_sync_q[8];

    // Command decode: fire once per write when stages 2/3 agree; the flag only
    // rearms on a genuine return to NOP seen after the sync chain has refilled,
    // so a command held through reset cannot fire again.
    always_comb begin
        instr_s3_d  = instr_s2;
        warm_d      = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        cmd_fire    = cmd_armed_q && (instr_s2 == instr_s3_q) && (instr_s3_q != CMD_NOP);
        cmd_armed_d = cmd_armed_q;
        if (cmd_fire) begin
            cmd_armed_d = 1'b0;
        end else if ((warm_q == 2'd3) && (instr_s3_q == CMD_NOP)) begin
            cmd_armed_d = 1'b1;
        end
        cmd_arm   = cmd_fire && (instr_s3_q == CMD_ARM);
        cmd_soft  = cmd_fire && (instr_s3_q == CMD_SOFT_TRIG);
        cmd_abort = cmd_fire && (instr_s3_q == CMD_ABORT);
        trig_acc  = (ext_rise && mode_s[0]) || (cmd_soft && mode_s[1]);
    end

    // Command-path flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_s3_q  <= CMD_NOP;
            warm_q      <= '0;
            cmd_armed_q <= 1'b0;
        end else begin
            instr_s3_q  <= instr_s3_d;
            warm_q      <= warm_d;
            cmd_armed_q <= cmd_armed_d;
        end
    end

    assign tick = !slow_s || (PRESCALE_LOG2 == 0) || (&presc_q);

    // Next-state logic; ABORT overrides everything, including a coincident trigger.
    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        presc_d    = presc_q + 1'b1;
        trig_taken = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_arm) state_d = ARMED;
            end
            ARMED: begin
                if (trig_acc) begin
                    state_d    = DELAY;
                    dly_cnt_d  = delay_s;
                    presc_d    = '0;
                    trig_taken = 1'b1;
                end
            end
            DELAY: begin
                if (dly_cnt_q == '0) begin
                    state_d = STOP;
                end else if (tick) begin
                    dly_cnt_d = dly_cnt_q - 6'd1;
                end
            end
            STOP: begin
                state_d = DONE;
            end
            DONE: begin
                if (cmd_arm) state_d = ARMED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (cmd_abort) begin
            state_d    = IDLE;
            trig_taken = 1'b0;
        end
    end

    // State register with outputs decoded from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dly_cnt_q    <= '0;
            presc_q      <= '0;
            sample_en_q  <= 1'b0;
            stop_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_cnt_q    <= dly_cnt_d;
            presc_q      <= presc_d;
            sample_en_q  <= is_sampling(state_d);
            stop_pulse_q <= (state_d == STOP);
            busy_q       <= is_busy(state_d);
            done_q       <= (state_d == DONE);
        end
    end

    assign sample_en  = sample_en_q;
    assign stop_pulse = stop_pulse_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

`ifdef ACQ_CTRL_TRIG_COUNT_EN
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;

    // Saturating count of triggers that actually started a delay.
    always_comb begin
        trig_cnt_d = trig_cnt_q;
        if (trig_taken && !(&trig_cnt_q)) trig_cnt_d = trig_cnt_q + 1'b1;
    end

    // Trigger counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) trig_cnt_q <= '0;
        else     trig_cnt_q <= trig_cnt_d;
    end

    assign trig_count = trig_cnt_q;
`else
    logic unused_trig_taken;
    assign unused_trig_taken = trig_taken;
    assign trig_count        = '0;
`endif

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed bench for acq_ctrl: timing of command/trigger paths, delay lengths,
// mode gating, abort priority, one-shot commands, reset and trigger counting.
module tb_acq_ctrl;
    import acq_ctrl_pkg::*;

    localparam int CNT_W = 16;

    // {state_dbg, sample_en, stop_pulse, busy, done}
    localparam logic [6:0] O_IDLE  = 7'b000_0_0_0_0;
    localparam logic [6:0] O_ARMED = 7'b001_1_0_1_0;
    localparam logic [6:0] O_DELAY = 7'b010_1_0_1_0;
    localparam logic [6:0] O_STOP  = 7'b011_0_1_1_0;
    localparam logic [6:0] O_DONE  = 7'b100_0_0_0_1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       instruction;
    logic [1:0]       mode;
    logic [5:0]       trigger_delay;
    logic             slow_mode;
    logic             trig_in;
    logic             sample_en, stop_pulse, busy, done;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] trig_count;
    logic [6:0]       obs;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    assign obs = {state_dbg, sample_en, stop_pulse, busy, done};

    acq_ctrl #(.PRESCALE_LOG2(2), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .mode          (mode),
        .trigger_delay (trigger_delay),
        .slow_mode     (slow_mode),
        .trig_in       (trig_in),
        .sample_en     (sample_en),
        .stop_pulse    (stop_pulse),
        .busy          (busy),
        .done          (done),
        .state_dbg     (state_dbg),
        .trig_count    (trig_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] c);
        instruction = c;
        tick(4);
        instruction = CMD_NOP;
        tick(4);
    endtask

    task automatic check_cnt(input string name);
        logic [CNT_W-1:0] want;
`ifdef ACQ_CTRL_TRIG_COUNT_EN
        want = CNT_W'(exp_cnt);
`else
        want = '0;
`endif
        checks++;
        if (trig_count !== want) begin
            errors++;
            $display("FAIL %s: trig_count got %0d expected %0d", name, trig_count, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; instruction = CMD_NOP; mode = 2'b00; trigger_delay = '0;
        slow_mode = 1'b0; trig_in = 1'b0;
        tick(3);
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, O_IDLE); end
        rst = 1'b0;
        tick(6);
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL post_reset_idle: got %b expected %b", obs, O_IDLE); end
        exp_cnt = 0;
        check_cnt("reset_count");
    endtask

    task automatic test_fast_delay;
        mode = 2'b11; trigger_delay = 6'd5; slow_mode = 1'b0;
        tick(4);
        instruction = CMD_ARM;
        tick(3);
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL arm_latency_early: got %b expected %b", obs, O_IDLE); end
        tick(1);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL arm_latency: got %b expected %b", obs, O_ARMED); end
        instruction = CMD_NOP;
        tick(4);
        trig_in = 1'b1;
        tick(3);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL trig_latency_early: got %b expected %b", obs, O_ARMED); end
        tick(1);
        exp_cnt++;
        checks++;
        if (obs !== O_DELAY) begin errors++; $display("FAIL trig_latency: got %b expected %b", obs, O_DELAY); end
        trig_in = 1'b0;
        tick(5);
        checks++;
        if (obs !== O_DELAY) begin errors++; $display("FAIL fast_delay_hold: got %b expected %b", obs, O_DELAY); end
        tick(1);
        checks++;
        if (obs !== O_STOP) begin errors++; $display("FAIL fast_stop: got %b expected %b", obs, O_STOP); end
        tick(1);
        checks++;
        if (obs !== O_DONE) begin errors++; $display("FAIL fast_done: got %b expected %b", obs, O_DONE); end
        check_cnt("fast_count");
    endtask

    task automatic test_slow_delay;
        cmd(CMD_ABORT);
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL abort_from_done: got %b expected %b", obs, O_IDLE); end
        slow_mode = 1'b1; trigger_delay = 6'd2;
        tick(4);
        cmd(CMD_ARM);
        instruction = CMD_SOFT_TRIG;
        tick(4);
        exp_cnt++;
        checks++;
        if (obs !== O_DELAY) begin errors++; $display("FAIL soft_trig_entry: got %b expected %b", obs, O_DELAY); end
        instruction = CMD_NOP;
        tick(8);
        checks++;
        if (obs !== O_DELAY) begin errors++; $display("FAIL slow_delay_hold: got %b expected %b", obs, O_DELAY); end
        tick(1);
        checks++;
        if (obs !== O_STOP) begin errors++; $display("FAIL slow_stop: got %b expected %b", obs, O_STOP); end
        tick(4);
        cmd(CMD_ABORT);
        trigger_delay = 6'd0;
        tick(4);
        cmd(CMD_ARM);
        instruction = CMD_SOFT_TRIG;
        tick(4);
        exp_cnt++;
        checks++;
        if (obs !== O_DELAY) begin errors++; $display("FAIL zero_delay_entry: got %b expected %b", obs, O_DELAY); end
        tick(1);
        checks++;
        if (obs !== O_STOP) begin errors++; $display("FAIL zero_delay_stop: got %b expected %b", obs, O_STOP); end
        instruction = CMD_NOP;
        tick(4);
        check_cnt("slow_count");
    endtask

    task automatic test_mode_gating;
        cmd(CMD_ABORT);
        mode = 2'b10; slow_mode = 1'b0; trigger_delay = 6'd1;
        tick(4);
        cmd(CMD_ARM);
        trig_in = 1'b1;
        tick(6);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL ext_gated: got %b expected %b", obs, O_ARMED); end
        trig_in = 1'b0;
        cmd(CMD_ABORT);
        mode = 2'b01;
        tick(4);
        cmd(CMD_ARM);
        cmd(CMD_SOFT_TRIG);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL soft_gated: got %b expected %b", obs, O_ARMED); end
        check_cnt("gated_count");
    endtask

    task automatic test_abort_vs_trigger;
        instruction = CMD_ABORT;
        trig_in = 1'b1;
        tick(3);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL abort_early: got %b expected %b", obs, O_ARMED); end
        tick(1);
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL abort_wins: got %b expected %b", obs, O_IDLE); end
        tick(2);
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL abort_no_stop: got %b expected %b", obs, O_IDLE); end
        instruction = CMD_NOP;
        trig_in = 1'b0;
        tick(4);
        check_cnt("abort_count");
    endtask

    task automatic test_one_shot;
        trigger_delay = 6'd3;
        tick(4);
        cmd(CMD_ARM);
        trig_in = 1'b1;
        tick(4);
        exp_cnt++;
        trig_in = 1'b0;
        tick(6);
        checks++;
        if (obs !== O_DONE) begin errors++; $display("FAIL oneshot_first_done: got %b expected %b", obs, O_DONE); end
        instruction = CMD_ARM;
        tick(4);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL rearm: got %b expected %b", obs, O_ARMED); end
        trig_in = 1'b1;
        tick(4);
        exp_cnt++;
        trig_in = 1'b0;
        tick(42);
        checks++;
        if (obs !== O_DONE) begin errors++; $display("FAIL held_arm_single: got %b expected %b", obs, O_DONE); end
        instruction = CMD_NOP;
        tick(4);
        cmd(CMD_ARM);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL rearm_after_release: got %b expected %b", obs, O_ARMED); end
        check_cnt("oneshot_count");
        trig_in = 1'b1;
        tick(4);
        checks++;
        if (obs !== O_DELAY) begin errors++; $display("FAIL pre_rst_delay: got %b expected %b", obs, O_DELAY); end
        rst = 1'b1;
        tick(1);
        exp_cnt = 0;
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL rst_mid_delay: got %b expected %b", obs, O_IDLE); end
        check_cnt("rst_count");
        trig_in = 1'b0;
        instruction = CMD_ARM;
        tick(1);
        rst = 1'b0;
        tick(10);
        checks++;
        if (obs !== O_IDLE) begin errors++; $display("FAIL held_across_reset: got %b expected %b", obs, O_IDLE); end
        instruction = CMD_NOP;
        tick(5);
    endtask

    task automatic test_back_to_back;
        mode = 2'b01; trigger_delay = 6'd0; slow_mode = 1'b0;
        tick(4);
        cmd(CMD_ARM);
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL b2b_arm: got %b expected %b", obs, O_ARMED); end
        for (int i = 0; i < 3; i++) begin
            trig_in = 1'b1;
            tick(4);
            exp_cnt++;
            trig_in = 1'b0;
            tick(2);
            checks++;
            if (obs !== O_DONE) begin errors++; $display("FAIL b2b_done_%0d: got %b expected %b", i, obs, O_DONE); end
            trig_in = 1'b1;
            tick(5);
            trig_in = 1'b0;
            tick(2);
            check_cnt("b2b_drop_in_done");
            cmd(CMD_ARM);
        end
        checks++;
        if (obs !== O_ARMED) begin errors++; $display("FAIL b2b_final_armed: got %b expected %b", obs, O_ARMED); end
        check_cnt("b2b_total");
    endtask

    initial begin
        test_reset();
        test_fast_delay();
        test_slow_delay();
        test_mode_gating();
        test_abort_vs_trigger();
        test_one_shot();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
